// File: rtl/i2c_seq_pkg.sv
// Shared types and register encodings for the i2c_seq master-transaction sequencer.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_GO, S_WAIT_IRQ, S_RD_STAT, S_CLR, S_CHECK,
    S_RD_DATA, S_STOP_WR, S_STOP_POLL, S_ABORT, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_DEV_W, PH_REG, PH_WDATA, PH_DEV_R, PH_RDATA
  } phase_t;

  localparam int CTRL_EN   = 7;
  localparam int CTRL_IEN  = 6;
  localparam int CTRL_MSTA = 5;
  localparam int CTRL_MRD  = 4;
  localparam int CTRL_NACK = 3;
  localparam int CTRL_RSTA = 2;

  localparam int STAT_DONE   = 7;
  localparam int STAT_BUSY   = 6;
  localparam int STAT_ARB    = 5;
  localparam int STAT_RXNACK = 4;
  localparam int STAT_IRQ    = 0;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_ARB  = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  localparam logic [7:0] CTRL_GO   = 8'hE0;
  localparam logic [7:0] CTRL_STOP = 8'hC0;
  localparam logic [7:0] CTRL_OFF  = 8'h00;

  // CTRL value that launches one byte in the given phase.
  function automatic logic [7:0] go_ctrl(input phase_t ph);
    logic [7:0] v;
    v = CTRL_GO;
    if (ph == PH_DEV_R) v[CTRL_RSTA] = 1'b1;
    if (ph == PH_RDATA) begin
      v[CTRL_MRD]  = 1'b1;
      v[CTRL_NACK] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/i2c_wb_master.sv
// Single-access Wishbone master: one start launches one access, done pulses on its ack.
module i2c_wb_master (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] wb_add_o,
  output logic [7:0] wb_data_o,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic [7:0] wb_data_i,
  input  logic       wb_ack_i
);

  logic       stb_q, stb_d;
  logic       we_q, we_d;
  logic [7:0] add_q, add_d;
  logic [7:0] dat_q, dat_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    stb_d = stb_q;
    we_d  = we_q;
    add_d = add_q;
    dat_d = dat_q;
    if (stb_q) begin
      if (wb_ack_i) begin
        stb_d = 1'b0;
        we_d  = 1'b0;
        add_d = 8'h00;
        dat_d = 8'h00;
      end
    end else if (start) begin
      stb_d = 1'b1;
      we_d  = we;
      add_d = addr;
      dat_d = we ? wdata : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      add_q <= 8'h00;
      dat_q <= 8'h00;
    end else begin
      stb_q <= stb_d;
      we_q  <= we_d;
      add_q <= add_d;
      dat_q <= dat_d;
    end
  end

  // An ack outside an active strobe never completes anything.
  assign done      = stb_q & wb_ack_i;
  assign rdata     = wb_data_i;
  assign wb_add_o  = add_q;
  assign wb_data_o = dat_q;
  assign wb_we_o   = we_q;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = stb_q;

endmodule

// File: rtl/i2c_seq.sv
// Sequencer that runs single-byte I2C register writes/reads by programming the i2c_blk core.
module i2c_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [7:0] ADDR_CTRL = 8'h00,
  parameter logic [7:0] ADDR_STAT = 8'h01,
  parameter logic [7:0] ADDR_DATA = 8'h02,
  parameter int         TO_CYCLES = 4096,
  parameter int         TO_W      = 13
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [1:0] rsp_err,
  output logic [7:0] rsp_rdata,
  output logic [7:0] wb_add_o,
  output logic [7:0] wb_data_o,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic [7:0] wb_data_i,
  input  logic       wb_ack_i,
  input  logic       irq
);

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic            issued_q, issued_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            rw_q, rw_d;
  logic [6:0]      dev_q, dev_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            arb_q, arb_d;
  logic            nack_q, nack_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [1:0]      rsp_err_q, rsp_err_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;

  logic            acc_req, acc_we, start, done;
  logic [7:0]      acc_addr, acc_wdata, acc_rdata, load_byte;
  logic            abort_now, timed_out;
  logic [1:0]      abort_err;

  i2c_wb_master u_wb (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .start     (start),
    .we        (acc_we),
    .addr      (acc_addr),
    .wdata     (acc_wdata),
    .done      (done),
    .rdata     (acc_rdata),
    .wb_add_o  (wb_add_o),
    .wb_data_o (wb_data_o),
    .wb_we_o   (wb_we_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_data_i (wb_data_i),
    .wb_ack_i  (wb_ack_i)
  );

  // Fires on the TO_CYCLES-th cycle spent waiting since the counter was reloaded.
  assign timed_out = (to_cnt_q >= TO_W'(TO_CYCLES - 1));

  always_comb begin
    load_byte = 8'h00;
    case (phase_q)
      PH_DEV_W: load_byte = {dev_q, 1'b0};
      PH_REG:   load_byte = reg_q;
      PH_WDATA: load_byte = wdata_q;
      PH_DEV_R: load_byte = {dev_q, 1'b1};
      default:  load_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    issued_d    = issued_q;
    to_cnt_d    = to_cnt_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    arb_d       = arb_q;
    nack_d      = nack_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    acc_req     = 1'b0;
    acc_we      = 1'b0;
    acc_addr    = ADDR_CTRL;
    acc_wdata   = 8'h00;
    start       = 1'b0;
    abort_now   = 1'b0;
    abort_err   = ERR_OK;

    case (state_q)
      S_IDLE: if (req_valid) begin
        rw_d        = req_rw;
        dev_d       = req_dev;
        reg_d       = req_reg;
        wdata_d     = req_wdata;
        phase_d     = PH_DEV_W;
        rsp_err_d   = ERR_OK;
        rsp_rdata_d = 8'h00;
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = ADDR_DATA;
        acc_wdata = load_byte;
        if (done) state_d = S_GO;
      end
      S_GO: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_wdata = go_ctrl(phase_q);
        if (done) begin
          state_d  = S_WAIT_IRQ;
          to_cnt_d = '0;
        end
      end
      S_WAIT_IRQ: begin
        if (irq) begin
          state_d = S_RD_STAT;
        end else if (timed_out) begin
          abort_now = 1'b1;
          abort_err = ERR_TO;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_RD_STAT: begin
        acc_req  = 1'b1;
        acc_addr = ADDR_STAT;
        if (done) begin
          arb_d   = acc_rdata[STAT_ARB];
          nack_d  = acc_rdata[STAT_RXNACK];
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = ADDR_STAT;
        acc_wdata = 8'h00;
        if (done) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (arb_q) begin
          abort_now = 1'b1;
          abort_err = ERR_ARB;
        end else if (nack_q && phase_q != PH_RDATA) begin
          abort_now = 1'b1;
          abort_err = ERR_NACK;
        end else begin
          case (phase_q)
            PH_DEV_W: begin phase_d = PH_REG;   state_d = S_LOAD; end
            PH_REG:   begin phase_d = rw_q ? PH_DEV_R : PH_WDATA; state_d = S_LOAD; end
            PH_WDATA: state_d = S_STOP_WR;
            PH_DEV_R: begin phase_d = PH_RDATA; state_d = S_GO; end
            default:  state_d = S_RD_DATA;
          endcase
        end
      end
      S_RD_DATA: begin
        acc_req  = 1'b1;
        acc_addr = ADDR_DATA;
        if (done) begin
          rsp_rdata_d = acc_rdata;
          state_d     = S_STOP_WR;
        end
      end
      S_STOP_WR: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_wdata = CTRL_STOP;
        if (done) begin
          state_d  = S_STOP_POLL;
          to_cnt_d = '0;
        end
      end
      S_STOP_POLL: begin
        acc_req  = 1'b1;
        acc_addr = ADDR_STAT;
        to_cnt_d = to_cnt_q + 1'b1;
        if (done && !acc_rdata[STAT_BUSY]) begin
          state_d = S_DONE;
        end else if (!issued_q && timed_out) begin
          abort_now = 1'b1;
          abort_err = ERR_TO;
        end
      end
      S_ABORT: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_wdata = CTRL_OFF;
        if (done) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (acc_req && !issued_q) begin
      start    = 1'b1;
      issued_d = 1'b1;
    end
    if (done) issued_d = 1'b0;

    // The disabling CTRL write is launched in the same cycle the error is found.
    if (abort_now) begin
      start     = 1'b1;
      acc_we    = 1'b1;
      acc_addr  = ADDR_CTRL;
      acc_wdata = CTRL_OFF;
      issued_d  = 1'b1;
      rsp_err_d = abort_err;
      state_d   = S_ABORT;
    end
  end

  assign rsp_valid_d = (state_d == S_DONE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_DEV_W;
      issued_q    <= 1'b0;
      to_cnt_q    <= '0;
      rw_q        <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      arb_q       <= 1'b0;
      nack_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= ERR_OK;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      issued_q    <= issued_d;
      to_cnt_q    <= to_cnt_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      arb_q       <= arb_d;
      nack_q      <= nack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_i2c_seq.sv
// Directed bench for i2c_seq against a small behavioural model of the i2c_blk register port.
module tb_i2c_seq;

  localparam int TO_CYCLES = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_rw = 1'b0;
  logic [6:0] req_dev = 7'h00;
  logic [7:0] req_reg = 8'h00, req_wdata = 8'h00;
  logic       req_ready, rsp_valid;
  logic [1:0] rsp_err;
  logic [7:0] rsp_rdata;
  logic [7:0] wb_add_o, wb_data_o, wb_data_i;
  logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2c_seq #(.TO_CYCLES(TO_CYCLES)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_dev    (req_dev),
    .req_reg    (req_reg),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .wb_add_o   (wb_add_o),
    .wb_data_o  (wb_data_o),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_data_i  (wb_data_i),
    .wb_ack_i   (wb_ack_i),
    .irq        (irq)
  );

  // Core model: acks one cycle after strobe, raises irq a few cycles after each byte launch.
  logic        model_clr = 1'b0, spur_ack = 1'b0, m_ack = 1'b0;
  logic [7:0]  m_ctrl = 8'h00, m_stat = 8'h00, m_data = 8'h00;
  int          m_irq_cnt = 0, m_busy_cnt = 0, m_go_cnt = 0, m_nwr = 0;
  logic [15:0] m_log [32];
  int          cfg_nack_at = 0, cfg_arb_at = 0;
  logic        cfg_no_irq = 1'b0;
  logic [7:0]  cfg_rdata = 8'h00;

  assign wb_ack_i = m_ack | spur_ack;
  assign irq      = m_stat[0];

  always_comb begin
    case (wb_add_o)
      8'h01:   wb_data_i = m_stat;
      8'h02:   wb_data_i = m_data;
      default: wb_data_i = m_ctrl;
    endcase
  end

  always @(posedge clk) begin
    m_ack <= wb_stb_o && wb_cyc_o && !m_ack;
    if (model_clr) begin
      m_stat <= 8'h00; m_ctrl <= 8'h00; m_data <= 8'h00;
      m_irq_cnt <= 0; m_busy_cnt <= 0; m_go_cnt <= 0; m_nwr <= 0;
    end else begin
      if (m_irq_cnt > 0) begin
        m_irq_cnt <= m_irq_cnt - 1;
        if (m_irq_cnt == 1) m_stat <= m_stat | 8'h81;
      end
      if (m_busy_cnt > 0) begin
        m_busy_cnt <= m_busy_cnt - 1;
        if (m_busy_cnt == 1) m_stat <= m_stat & 8'hBF;
      end
      if (wb_stb_o && m_ack && wb_we_o) begin
        if (m_nwr < 32) m_log[m_nwr] <= {wb_add_o, wb_data_o};
        m_nwr <= m_nwr + 1;
        case (wb_add_o)
          8'h00: begin
            m_ctrl <= wb_data_o;
            if (wb_data_o[5]) begin
              m_go_cnt <= m_go_cnt + 1;
              m_stat <= 8'h40 | ((cfg_nack_at == m_go_cnt + 1) ? 8'h10 : 8'h00)
                              | ((cfg_arb_at  == m_go_cnt + 1) ? 8'h20 : 8'h00);
              if (!cfg_no_irq) m_irq_cnt <= 4;
              if (wb_data_o[4]) m_data <= cfg_rdata;
            end else if (wb_data_o == 8'hC0) begin
              m_busy_cnt <= 6;
            end else if (wb_data_o == 8'h00) begin
              m_stat <= m_stat & 8'hBF;
            end
          end
          8'h01:   if (wb_data_o == 8'h00) m_stat <= m_stat & 8'hFE;
          8'h02:   m_data <= wb_data_o;
          default: ;
        endcase
      end
    end
  end

  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] rg, wd, rd;
    int         nack_at, arb_at;
    logic       no_irq;
    logic [1:0] err;
    logic [7:0] rdata;
    int         n_wr;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] exp_wr [7][12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd);
    req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
    @(negedge clk);
    // Scramble the fields after acceptance: the sequencer must have latched them.
    req_valid = 1'b0; req_rw = ~rw; req_dev = 7'h7F; req_reg = 8'hFF; req_wdata = 8'hFF;
  endtask

  task automatic run_vec(input int i);
    logic got, ready_bad;
    int   c, t_entry, lat;
    @(negedge clk);
    cfg_nack_at = vecs[i].nack_at; cfg_arb_at = vecs[i].arb_at;
    cfg_no_irq = vecs[i].no_irq;   cfg_rdata = vecs[i].rd;
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
    send_req(vecs[i].rw, vecs[i].dev, vecs[i].rg, vecs[i].wd);
    got = 1'b0; ready_bad = 1'b0; t_entry = 0; lat = 0; c = 0;
    while (!got && c < 20000) begin
      if (rsp_valid) begin
        got = 1'b1;
        lat = c - t_entry;
      end else begin
        if (req_ready) ready_bad = 1'b1;
        if (wb_stb_o && wb_ack_i && wb_we_o && wb_add_o == 8'h00 && wb_data_o == 8'hE0)
          t_entry = c + 1;
        @(negedge clk);
        c++;
      end
    end
    check($sformatf("v%0d_rsp_seen", i), got, 1);
    check($sformatf("v%0d_err", i), rsp_err, vecs[i].err);
    check($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].rdata);
    check($sformatf("v%0d_ready_low", i), ready_bad, 0);
    check($sformatf("v%0d_nwr", i), m_nwr, vecs[i].n_wr);
    for (int k = 0; k < vecs[i].n_wr; k++)
      check($sformatf("v%0d_wr%0d", i, k), m_log[k], exp_wr[i][k]);
    if (vecs[i].no_irq) begin
      n_checks++;
      if (lat < TO_CYCLES - 2 || lat > TO_CYCLES + 2) begin
        n_fail++;
        $display("FAIL v%0d_to_latency: got %0d cycles, expected %0d +-2", i, lat, TO_CYCLES);
      end
    end
    @(negedge clk);
    check($sformatf("v%0d_valid_1cyc", i), rsp_valid, 0);
    check($sformatf("v%0d_ready_after", i), req_ready, 1);
    check($sformatf("v%0d_err_hold", i), rsp_err, vecs[i].err);
  endtask

  initial begin
    vecs[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 0, 1'b0, 2'b00, 8'h00, 10};
    vecs[1] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, 0, 1'b0, 2'b01, 8'h00, 4};
    vecs[2] = '{1'b1, 7'h50, 8'h10, 8'h00, 8'h00, 2, 2, 1'b0, 2'b10, 8'h00, 7};
    vecs[3] = '{1'b0, 7'h22, 8'h33, 8'h44, 8'h00, 0, 0, 1'b1, 2'b11, 8'h00, 3};
    vecs[4] = '{1'b0, 7'h2A, 8'h01, 8'h7E, 8'h00, 0, 0, 1'b0, 2'b00, 8'h00, 10};
    vecs[5] = '{1'b1, 7'h1B, 8'hC4, 8'h00, 8'h5A, 4, 0, 1'b0, 2'b00, 8'h5A, 12};
    vecs[6] = '{1'b1, 7'h50, 8'h10, 8'h00, 8'h3C, 0, 0, 1'b0, 2'b00, 8'h3C, 12};
    exp_wr[0] = '{16'h02A0, 16'h00E0, 16'h0100, 16'h0210, 16'h00E0, 16'h0100,
                  16'h02A5, 16'h00E0, 16'h0100, 16'h00C0, 16'h0000, 16'h0000};
    exp_wr[1] = '{16'h02A0, 16'h00E0, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp_wr[2] = '{16'h02A0, 16'h00E0, 16'h0100, 16'h0210, 16'h00E0, 16'h0100,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp_wr[3] = '{16'h0244, 16'h00E0, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp_wr[4] = '{16'h0254, 16'h00E0, 16'h0100, 16'h0201, 16'h00E0, 16'h0100,
                  16'h027E, 16'h00E0, 16'h0100, 16'h00C0, 16'h0000, 16'h0000};
    exp_wr[5] = '{16'h0236, 16'h00E0, 16'h0100, 16'h02C4, 16'h00E0, 16'h0100,
                  16'h0237, 16'h00E4, 16'h0100, 16'h00F8, 16'h0100, 16'h00C0};
    exp_wr[6] = '{16'h02A0, 16'h00E0, 16'h0100, 16'h0210, 16'h00E0, 16'h0100,
                  16'h02A1, 16'h00E4, 16'h0100, 16'h00F8, 16'h0100, 16'h00C0};

    #1;
    check("rst_ready", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_err", rsp_err, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_wb", {wb_cyc_o, wb_stb_o, wb_we_o, wb_add_o, wb_data_o}, 0);
    model_clr = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clr = 1'b0;

    // Stray ack while idle must not start anything.
    @(negedge clk); spur_ack = 1'b1;
    @(negedge clk); spur_ack = 1'b0;
    @(negedge clk);
    check("spur_ack_idle", {wb_cyc_o, req_ready, rsp_valid}, 3'b010);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Reset while waiting for irq.
    begin
      logic seen;
      int   pulses;
      @(negedge clk);
      cfg_no_irq = 1'b1; cfg_nack_at = 0; cfg_arb_at = 0; model_clr = 1'b1;
      @(negedge clk); model_clr = 1'b0;
      send_req(1'b1, 7'h50, 8'h10, 8'h00);
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if (!seen && wb_stb_o && wb_ack_i && wb_add_o == 8'h00 && wb_data_o == 8'hE0) seen = 1'b1;
        @(negedge clk);
      end
      check("rstw_reached_wait", seen, 1);
      check("rstw_busy", req_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      check("rstw_ready", req_ready, 1);
      check("rstw_outs", {rsp_valid, rsp_err, rsp_rdata, wb_cyc_o, wb_stb_o}, 0);

      // Reset in the middle of an active strobe.
      @(negedge clk); rst_n = 1'b1;
      model_clr = 1'b1;
      @(negedge clk); model_clr = 1'b0;
      send_req(1'b0, 7'h50, 8'h10, 8'hA5);
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
        if (!seen) begin
          if (wb_stb_o) seen = 1'b1;
          else @(negedge clk);
        end
      end
      check("rsts_stb_seen", seen, 1);
      #1 rst_n = 1'b0;
      #1;
      check("rsts_wb", {wb_cyc_o, wb_stb_o, wb_we_o, wb_add_o, wb_data_o}, 0);
      check("rsts_ready", req_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (rsp_valid) pulses++;
      end
      check("rst_no_rsp", pulses, 0);
      check("rst_idle_ready", req_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
